// File: rtl/bus_arbiter.sv
// ============================================================================
//  Module      : bus_arbiter
//  Description : Round-robin one-hot bus source arbiter with hold limit and
//                a dead turnaround cycle between consecutive grants.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module bus_arbiter #(
    parameter int NREQ     = 24,
    parameter int HOLD_MAX = 8
) (
    input  logic            clock,
    input  logic            clear,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [4:0]      gnt_idx,
    output logic            bus_busy,
    output logic            timeout
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_TURN  = 2'd2
    } state_t;

    localparam logic [4:0] c_hold = 5'(HOLD_MAX);
    localparam logic [4:0] c_last = 5'(NREQ - 1);
    localparam logic [5:0] c_nreq = 6'(NREQ);

    state_t          r_state, w_state;
    logic [NREQ-1:0] r_gnt, w_gnt;
    logic [4:0]      r_win, w_win;
    logic [4:0]      r_cnt, w_cnt;
    logic [4:0]      r_ptr, w_ptr;
    logic            r_timeout, w_timeout;

    logic            w_found;
    logic [4:0]      w_pick;
    logic [5:0]      w_pos;
    logic [4:0]      w_idx;

    // First requesting source at or above the pointer, wrapping at NREQ-1.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_pos   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_pos = {1'b0, r_ptr} + 6'(k);
            if (w_pos >= c_nreq) begin
                w_pos = w_pos - c_nreq;
            end
            if (!w_found && req[w_pos[4:0]]) begin
                w_found = 1'b1;
                w_pick  = w_pos[4:0];
            end
        end
    end

    always_comb begin
        w_state   = r_state;
        w_gnt     = r_gnt;
        w_win     = r_win;
        w_cnt     = r_cnt;
        w_ptr     = r_ptr;
        w_timeout = 1'b0;
        case (r_state)
            S_IDLE, S_TURN: begin
                w_gnt   = '0;
                w_cnt   = '0;
                w_state = S_IDLE;
                if (w_found) begin
                    w_state        = S_GRANT;
                    w_gnt[w_pick]  = 1'b1;
                    w_win          = w_pick;
                    w_cnt          = 5'd1;
                end
            end
            S_GRANT: begin
                // A release on the limit cycle counts as normal, so timeout
                // only fires when the winner is still requesting.
                if (!req[r_win] || (r_cnt == c_hold)) begin
                    w_state   = S_TURN;
                    w_gnt     = '0;
                    w_ptr     = (r_win == c_last) ? 5'd0 : r_win + 5'd1;
                    w_timeout = req[r_win];
                end else begin
                    w_cnt = r_cnt + 5'd1;
                end
            end
            default: begin
                w_state = S_IDLE;
                w_gnt   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_state   <= S_IDLE;
            r_gnt     <= '0;
            r_win     <= '0;
            r_cnt     <= '0;
            r_ptr     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_gnt     <= w_gnt;
            r_win     <= w_win;
            r_cnt     <= w_cnt;
            r_ptr     <= w_ptr;
            r_timeout <= w_timeout;
        end
    end

    // Index is encoded from the registered one-hot so it always tracks gnt.
    always_comb begin
        w_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_gnt[i]) begin
                w_idx = w_idx | 5'(i);
            end
        end
    end

    assign gnt      = r_gnt;
    assign gnt_idx  = w_idx;
    assign bus_busy = |r_gnt;
    assign timeout  = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter.sv
// ============================================================================
//  Module      : tb_bus_arbiter
//  Description : Directed self-checking bench for bus_arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bus_arbiter;

    localparam int NREQ     = 24;
    localparam int HOLD_MAX = 8;

    logic            clock;
    logic            clear;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] gnt;
    logic [4:0]      gnt_idx;
    logic            bus_busy;
    logic            timeout;

    int n_tests = 0;
    int n_fail  = 0;

    bus_arbiter #(
        .NREQ     (NREQ),
        .HOLD_MAX (HOLD_MAX)
    ) dut (
        .clock    (clock),
        .clear    (clear),
        .req      (req),
        .gnt      (gnt),
        .gnt_idx  (gnt_idx),
        .bus_busy (bus_busy),
        .timeout  (timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [NREQ-1:0] oh(input int b);
        logic [NREQ-1:0] v;
        v    = '0;
        v[b] = 1'b1;
        return v;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    always @(negedge clock) begin
        check_eq("onehot", 32'($onehot0(gnt)), 32'd1);
        check_eq("idx_range", 32'(gnt_idx < 5'(NREQ)), 32'd1);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    int rr[3] = '{22, 23, 1};

    initial begin
        clear = 1'b0;
        req   = '1;
        repeat (3) tick();
        check_eq("rst_gnt",  32'(gnt), 32'd0);
        check_eq("rst_idx",  32'(gnt_idx), 32'd0);
        check_eq("rst_busy", 32'(bus_busy), 32'd0);
        check_eq("rst_to",   32'(timeout), 32'd0);

        clear = 1'b1;
        tick();
        check_eq("first_gnt",  32'(gnt), 32'(oh(0)));
        check_eq("first_idx",  32'(gnt_idx), 32'd0);
        check_eq("first_busy", 32'(bus_busy), 32'd1);
        req = '0;
        tick();
        check_eq("first_turn", 32'(gnt), 32'd0);
        check_eq("first_to",   32'(timeout), 32'd0);
        tick();

        // single requester, three cycles
        req = oh(5);
        for (int c = 0; c < 3; c++) begin
            tick();
            check_eq("single_gnt", 32'(gnt), 32'(oh(5)));
            check_eq("single_idx", 32'(gnt_idx), 32'd5);
        end
        req = '0;
        tick();
        check_eq("single_turn", 32'(gnt), 32'd0);
        check_eq("single_busy", 32'(bus_busy), 32'd0);
        check_eq("single_to",   32'(timeout), 32'd0);
        tick();
        check_eq("single_idle", 32'(gnt), 32'd0);

        // move pointer to 22 via a short grant to 21 (ptr=6 -> picks 21)
        req = oh(21);
        tick();
        check_eq("pre_wrap_gnt", 32'(gnt), 32'(oh(21)));
        req = oh(1) | oh(22) | oh(23);
        tick();
        check_eq("pre_wrap_turn", 32'(gnt), 32'd0);

        // held requests: each served HOLD_MAX cycles, forced off, order 22,23,1
        for (int g = 0; g < 3; g++) begin
            for (int c = 0; c < HOLD_MAX; c++) begin
                tick();
                check_eq("wrap_gnt", 32'(gnt), 32'(oh(rr[g])));
                check_eq("wrap_to_low", 32'(timeout), 32'd0);
            end
            tick();
            check_eq("wrap_turn", 32'(gnt), 32'd0);
            check_eq("wrap_to", 32'(timeout), 32'd1);
        end
        req = '0;
        tick();
        check_eq("wrap_idle_gnt", 32'(gnt), 32'd0);
        check_eq("wrap_idle_to",  32'(timeout), 32'd0);

        // ptr=2: bit 10 times out, 12 and 4 arrive meanwhile without preempting
        req = oh(10);
        for (int c = 0; c < HOLD_MAX; c++) begin
            tick();
            check_eq("to_gnt", 32'(gnt), 32'(oh(10)));
            if (c == 2) req = req | oh(12) | oh(4);
        end
        tick();
        check_eq("to_turn", 32'(gnt), 32'd0);
        check_eq("to_pulse", 32'(timeout), 32'd1);
        tick();
        check_eq("to_next12", 32'(gnt), 32'(oh(12)));
        check_eq("to_pulse_off", 32'(timeout), 32'd0);
        req = req & ~oh(12);
        tick();
        check_eq("to_turn12", 32'(gnt), 32'd0);
        check_eq("to_norm12", 32'(timeout), 32'd0);
        tick();
        check_eq("to_next4", 32'(gnt), 32'(oh(4)));
        req = req & ~oh(4);
        tick();
        check_eq("to_turn4", 32'(gnt), 32'd0);
        tick();
        check_eq("to_regrant10", 32'(gnt), 32'(oh(10)));
        check_eq("to_regrant_idx", 32'(gnt_idx), 32'd10);
        req = '0;
        tick();
        check_eq("to_final_turn", 32'(gnt), 32'd0);
        tick();

        // ptr=11: bit 3 wins by wrap, drops exactly on the limit cycle
        req = oh(3);
        for (int c = 0; c < HOLD_MAX; c++) begin
            tick();
            check_eq("sim_gnt", 32'(gnt), 32'(oh(3)));
        end
        req = '0;
        tick();
        check_eq("sim_turn", 32'(gnt), 32'd0);
        check_eq("sim_to",   32'(timeout), 32'd0);
        check_eq("sim_busy", 32'(bus_busy), 32'd0);
        tick();

        // ptr=4: grant to 7, then asynchronous clear between edges
        req = oh(7);
        tick();
        check_eq("async_pre", 32'(gnt), 32'(oh(7)));
        #2;
        clear = 1'b0;
        req   = oh(2) | oh(7);
        #1;
        check_eq("async_gnt",  32'(gnt), 32'd0);
        check_eq("async_busy", 32'(bus_busy), 32'd0);
        check_eq("async_idx",  32'(gnt_idx), 32'd0);
        tick();
        check_eq("async_hold", 32'(gnt), 32'd0);
        clear = 1'b1;
        tick();
        check_eq("async_ptr0", 32'(gnt), 32'(oh(2)));
        check_eq("async_ptr0_idx", 32'(gnt_idx), 32'd2);
        req = '0;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
